serial_add_seq: RTL and testbench

Sequencer and result collector for the 4-bit serial adder stage. Accepts a pair of parallel operands over a valid/ready handshake. Clears the adder, then streams operand A and operand B into the adder's serial input LSB-first, with the adder's shift control asserted. It then clocks the adder for WIDTH more cycles while deserialising the adder's serial output into a parallel result, which it presents over a second valid/ready handshake.

---
 rtl/serial_add_seq.sv | 175 +++++++++++++++++
 tb/tb_serial_add_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - operand sequencer and result collector for the serial adder stage
//
// Takes an operand pair over a valid/ready handshake. It clears the adder, then
// streams op_a and op_b LSB-first into the adder with shift enabled. It then
// clocks the adder WIDTH more cycles while deserialising its output into result,
// and presents result over a second valid/ready handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   op_a, op_b          operands, op_a streamed first
//   ser_out, shift_en   serial bit and shift control to the adder
//   adder_clr_n         active-low adder clear
//   ser_in              serial sum from the adder
//   res_valid/res_ready result handshake
//   result              deserialised sum
//   res_parity          XOR of result bits (only with SERIAL_ADD_SEQ_PARITY_EN)
//
// Build option: define SERIAL_ADD_SEQ_PARITY_EN to add the res_parity output.

module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ser_out,
  output logic             shift_en,
  output logic             adder_clr_n,
  input  logic             ser_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result
`ifdef SERIAL_ADD_SEQ_PARITY_EN
  ,
  output logic             res_parity
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SHIFT_A, SHIFT_B, COLLECT, HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Holds the WIDTH-1 most recent collected bits; the oldest bit leaves this
  // register on the final collect edge and goes straight into result.
  logic [WIDTH-2:0] rsr_q, rsr_d;
  logic [WIDTH-1:0] collect_w;
  logic [WIDTH-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             ser_out_q, ser_out_d;
  logic             shift_en_q, shift_en_d;
  logic             adder_clr_n_q, adder_clr_n_d;
  logic             res_valid_q, res_valid_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    rsr_d     = rsr_q;
    result_d  = result_q;
    collect_w = {ser_in, rsr_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sa_d    = op_a;
          sb_d    = op_b;
          state_d = CLEAR;
        end
      end
      CLEAR:   state_d = SHIFT_A;
      SHIFT_A: if (cnt_q == CNT_LAST) state_d = SHIFT_B;
      SHIFT_B: if (cnt_q == CNT_LAST) state_d = COLLECT;
      COLLECT: begin
        rsr_d = collect_w[WIDTH-1:1];
        if (cnt_q == CNT_LAST) begin
          state_d  = HOLD;
          result_d = collect_w;
        end
      end
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == SHIFT_A || state_q == SHIFT_B || state_q == COLLECT) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are registered, so they are derived from the state being entered.
    ser_out_d  = 1'b0;
    shift_en_d = 1'b0;
    case (state_d)
      SHIFT_A: begin
        shift_en_d = 1'b1;
        ser_out_d  = sa_q[0];
        sa_d       = sa_q >> 1;
      end
      SHIFT_B: begin
        shift_en_d = 1'b1;
        ser_out_d  = sb_q[0];
        sb_d       = sb_q >> 1;
      end
      COLLECT: shift_en_d = 1'b1;
      default: ;
    endcase

    in_ready_d    = (state_d == IDLE);
    adder_clr_n_d = (state_d != CLEAR);
    res_valid_d   = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sa_q          <= '0;
      sb_q          <= '0;
      rsr_q         <= '0;
      result_q      <= '0;
      in_ready_q    <= 1'b1;
      ser_out_q     <= 1'b0;
      shift_en_q    <= 1'b0;
      adder_clr_n_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      rsr_q         <= rsr_d;
      result_q      <= result_d;
      in_ready_q    <= in_ready_d;
      ser_out_q     <= ser_out_d;
      shift_en_q    <= shift_en_d;
      adder_clr_n_q <= adder_clr_n_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign ser_out     = ser_out_q;
  assign shift_en    = shift_en_q;
  assign adder_clr_n = adder_clr_n_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;

`ifdef SERIAL_ADD_SEQ_PARITY_EN
  logic res_parity_q, res_parity_d;

  always_comb begin
    res_parity_d = ^result_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) res_parity_q <= 1'b0;
    else      res_parity_q <= res_parity_d;
  end

  assign res_parity = res_parity_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq with a behavioural serial adder

module tb_serial_add_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready, ser_out, shift_en, adder_clr_n, ser_in, res_valid;
  logic [W-1:0] result;
`ifdef SERIAL_ADD_SEQ_PARITY_EN
  logic         res_parity;
`endif

  serial_add_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .ser_out    (ser_out),
    .shift_en   (shift_en),
    .adder_clr_n(adder_clr_n),
    .ser_in     (ser_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result)
`ifdef SERIAL_ADD_SEQ_PARITY_EN
    ,
    .res_parity (res_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural serial adder: captures WIDTH bits of A then WIDTH bits of B
  // on shift edges, then emits (A+B) mod 2^W LSB-first on the next WIDTH shifts.
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;
  logic [4:0]   mn = '0;
  logic [W-1:0] msum;
  assign msum   = ma + mb;
  assign ser_in = (mn >= 5'd8 && mn < 5'd12) ? msum[mn[1:0]] : 1'b0;

  always @(posedge clk) begin
    if (!adder_clr_n) begin
      ma <= '0;
      mb <= '0;
      mn <= '0;
    end else if (shift_en) begin
      if (mn < 5'd4)      ma[mn[1:0]] <= ser_out;
      else if (mn < 5'd8) mb[mn[1:0]] <= ser_out;
      mn <= mn + 5'd1;
    end
  end

  // Scoreboard: expected sum pushed at the accepting edge, compared at transfer.
  int           cyc = 0;
  int           acc_edge = 0;
  int           xfer_edge = 0;
  logic [W-1:0] sbq[$];
  logic [W-1:0] sb_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      sbq.delete();
    end else begin
      if (in_valid && in_ready) begin
        sbq.push_back(op_a + op_b);
        acc_edge = cyc + 1;
      end
      if (res_valid && res_ready) begin
        xfer_edge = cyc + 1;
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL sb_pop: transfer of %0h with no pending operand pair", result);
        end else begin
          sb_exp = sbq.pop_front();
          check("sb_result", result, sb_exp);
`ifdef SERIAL_ADD_SEQ_PARITY_EN
          check("sb_parity", res_parity, ^sb_exp);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair and returns just after the accepting edge (edge 1).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_valid);
    int t;
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           stall;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int k;
    res_ready = (v.stall == 0);
    send(v.a, v.b, 1'b0);
    k = 1;
    while (!res_valid && k < 40) begin
      tick();
      k++;
    end
    check($sformatf("latency_%0h_%0h", v.a, v.b), k, 14);
    check($sformatf("result_%0h_%0h", v.a, v.b), result, v.exp);
`ifdef SERIAL_ADD_SEQ_PARITY_EN
    check($sformatf("parity_%0h_%0h", v.a, v.b), res_parity, ^v.exp);
`endif
    for (int i = 0; i < v.stall; i++) begin
      tick();
      check($sformatf("stall_result_%0d", i), result, v.exp);
      check($sformatf("stall_in_ready_%0d", i), in_ready, 0);
      check($sformatf("stall_valid_%0d", i), res_valid, 1);
    end
    res_ready = 1'b1;
    tick();
    check("xfer_in_ready", in_ready, 1);
    check("xfer_valid_low", res_valid, 0);
    res_ready = 1'b0;
  endtask

  vec_t         vecs[6];
  logic [11:0]  exp_ser;
  int           a1, k, vcount;

  initial begin
    vecs[0] = '{a: 4'hA, b: 4'h3, exp: 4'hD, stall: 5};
    vecs[1] = '{a: 4'hF, b: 4'h1, exp: 4'h0, stall: 0};
    vecs[2] = '{a: 4'h0, b: 4'h0, exp: 4'h0, stall: 0};
    vecs[3] = '{a: 4'h8, b: 4'h8, exp: 4'h0, stall: 2};
    vecs[4] = '{a: 4'h9, b: 4'h4, exp: 4'hD, stall: 1};
    vecs[5] = '{a: 4'hF, b: 4'hF, exp: 4'hE, stall: 0};

    // Reset state
    #1 rst = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_clr_n", adder_clr_n, 0);
    rst = 1'b1;
    #3;
    check("release_clr_n_before_edge", adder_clr_n, 0);
    tick();
    check("release_clr_n_after_edge", adder_clr_n, 1);
    check("release_in_ready", in_ready, 1);

    // Single add 0xA + 0x3 with the full serial waveform; accepting edge is edge 1
    res_ready = 1'b1;
    send(4'hA, 4'h3, 1'b0);
    exp_ser = {4'h0, 4'h3, 4'hA};
    check("e1_shift_en", shift_en, 0);
    check("e1_clr_n", adder_clr_n, 0);
    check("e1_in_ready", in_ready, 0);
    for (int e = 2; e <= 13; e++) begin
      tick();
      check($sformatf("e%0d_shift_en", e), shift_en, 1);
      check($sformatf("e%0d_ser_out", e), ser_out, exp_ser[e-2]);
      check($sformatf("e%0d_res_valid", e), res_valid, 0);
    end
    tick();
    check("e14_res_valid", res_valid, 1);
    check("e14_result", result, 4'hD);
    check("e14_shift_en", shift_en, 0);
    tick();
    check("e15_in_ready", in_ready, 1);
    check("e15_res_valid", res_valid, 0);
    res_ready = 1'b0;

    // Table: backpressure, wrap-around and assorted operands
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back with in_valid held; operand change after accept is ignored
    res_ready = 1'b1;
    send(4'h5, 4'h6, 1'b1);
    a1 = acc_edge;
    op_a = 4'h7;
    op_b = 4'h7;
    k = 0;
    while (acc_edge == a1 && k < 40) begin
      tick();
      k++;
    end
    check("b2b_first_latency", xfer_edge - a1, 14);
    check("b2b_idle_gap", acc_edge - xfer_edge, 1);
    in_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 40) begin
      tick();
      k++;
    end
    check("b2b_second_result", result, 4'hE);
    tick();
    res_ready = 1'b0;

    // Reset in the middle of SHIFT_B
    send(4'h9, 4'h9, 1'b0);
    repeat (6) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_shift_en", shift_en, 0);
    check("mid_rst_ser_out", ser_out, 0);
    check("mid_rst_clr_n", adder_clr_n, 0);
    check("mid_rst_result", result, 0);
    repeat (2) tick();
    rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid) vcount++;
    end
    check("mid_rst_no_result", vcount, 0);
    run_vec('{a: 4'h2, b: 4'h2, exp: 4'h4, stall: 0});

    repeat (2) tick();
    check("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
